multi_channel_pwm_timer: RTL and testbench

MULTI_CHANNEL_PWM_TIMER -- requirements
Module: multi_channel_pwm_timer

---
 rtl/multi_channel_pwm_timer_if.sv | 29 ++
 rtl/multi_channel_pwm_timer.sv | 187 ++++++++++++++++++
 tb/tb_multi_channel_pwm_timer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_pwm_timer_if.sv
// Avalon-MM slave bus bundle for multi_channel_pwm_timer.
// Address is {channel, offset[2:0]}.
interface multi_channel_pwm_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/multi_channel_pwm_timer.sv
// Multi-channel PWM timer with Avalon-MM register access.
// Optional PWM_SHADOW_EN: double-buffered PERIOD/COMPARE.
module multi_channel_pwm_timer #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 16,
  parameter int unsigned RST_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_channel_pwm_timer_if.slave  bus,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);

  localparam logic [CNT_W-1:0] P_INIT = CNT_W'(RST_PERIOD);

  logic              wr;
  logic [2:0]        off;
  logic [31:0]       ch_idx;
  logic [31:0]       wd;
  logic [CNT_W-1:0]  wd_cnt;
  logic [31:0]       rd_val;
  logic              unused_wd;

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] cont;
  logic [NUM_CH-1:0] pol;
  logic [CNT_W-1:0]  count   [NUM_CH];
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [CNT_W-1:0]  compare [NUM_CH];
  logic [CNT_W-1:0]  rd_per  [NUM_CH];
  logic [CNT_W-1:0]  rd_cmp  [NUM_CH];

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] wr_st;
  logic [NUM_CH-1:0] wr_ct;
  logic [NUM_CH-1:0] wr_pr;
  logic [NUM_CH-1:0] wr_cp;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] wrap;

  assign wr        = bus.chipselect && !bus.write_n;
  assign off       = bus.address[2:0];
  assign ch_idx    = 32'(bus.address) >> 3;
  assign wd        = bus.writedata;
  assign wd_cnt    = wd[CNT_W-1:0];
  assign unused_wd = ^wd;

  always_comb begin
    sel   = '0;
    wr_st = '0;
    wr_ct = '0;
    wr_pr = '0;
    wr_cp = '0;
    start = '0;
    stop  = '0;
    wrap  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]   = (ch_idx == 32'(c));
      wr_st[c] = wr && sel[c] && (off == 3'd0);
      wr_ct[c] = wr && sel[c] && (off == 3'd1);
      wr_pr[c] = wr && sel[c] && (off == 3'd2);
      wr_cp[c] = wr && sel[c] && (off == 3'd3);
      // STOP beats START when both strobes land together
      stop[c]  = wr_ct[c] && wd[3];
      start[c] = wr_ct[c] && wd[2] && !wd[3];
      wrap[c]  = run[c] && (count[c] == period[c]);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [CNT_W-1:0] sh_per [NUM_CH];
  logic [CNT_W-1:0] sh_cmp [NUM_CH];
  logic [NUM_CH-1:0] load;

  always_comb begin
    load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load[c]   = !run[c] || wrap[c] || start[c];
      rd_per[c] = sh_per[c];
      rd_cmp[c] = sh_cmp[c];
    end
  end

  // Active values follow the shadows only at safe points
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        sh_per[c]  <= P_INIT;
        sh_cmp[c]  <= '0;
        period[c]  <= P_INIT;
        compare[c] <= '0;
      end else begin
        if (wr_pr[c]) sh_per[c] <= wd_cnt;
        if (wr_cp[c]) sh_cmp[c] <= wd_cnt;
        if (load[c]) begin
          period[c]  <= wr_pr[c] ? wd_cnt : sh_per[c];
          compare[c] <= wr_cp[c] ? wd_cnt : sh_cmp[c];
        end
      end
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rd_per[c] = period[c];
      rd_cmp[c] = compare[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        period[c]  <= P_INIT;
        compare[c] <= '0;
      end else begin
        if (wr_pr[c]) period[c]  <= wd_cnt;
        if (wr_cp[c]) compare[c] <= wd_cnt;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        run[c]   <= 1'b0;
        to[c]    <= 1'b0;
        ie[c]    <= 1'b0;
        cont[c]  <= 1'b0;
        pol[c]   <= 1'b0;
        count[c] <= '0;
      end else begin
        if (wr_ct[c]) begin
          ie[c]   <= wd[0];
          cont[c] <= wd[1];
          pol[c]  <= wd[4];
        end
        if (stop[c]) begin
          run[c] <= 1'b0;
        end else if (start[c]) begin
          run[c]   <= 1'b1;
          count[c] <= '0;
        end else if (wrap[c]) begin
          count[c] <= '0;
          if (!cont[c]) run[c] <= 1'b0;
        end else if (run[c]) begin
          count[c] <= count[c] + 1'b1;
        end
        if (wrap[c])       to[c] <= 1'b1;
        else if (wr_st[c]) to[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        unique case (off)
          3'd0:    rd_val = {30'b0, run[c], to[c]};
          3'd1:    rd_val = {27'b0, pol[c], 2'b0, cont[c], ie[c]};
          3'd2:    rd_val = 32'(rd_per[c]);
          3'd3:    rd_val = 32'(rd_cmp[c]);
          3'd4:    rd_val = 32'(count[c]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_val;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pwm_out[c] = pol[c] ^ (run[c] && (count[c] < compare[c]));
    end
    irq = |(to & ie);
  end

endmodule

// File: tb/tb_multi_channel_pwm_timer.sv
// Directed bench for multi_channel_pwm_timer (NUM_CH=4, CNT_W=16).
// Register table plus hand-written timing sequences.
module tb_multi_channel_pwm_timer;

`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       irq;
  logic [3:0] pwm_out;
  int         checks;
  int         errors;

  multi_channel_pwm_timer_if #(.NUM_CH(4)) bus ();

  multi_channel_pwm_timer #(
    .NUM_CH(4),
    .CNT_W(16),
    .RST_PERIOD(49999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .irq(irq),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          do_wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp;
    bit          chk_pwm;
    logic        pwm2;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  function automatic logic [4:0] ad(input int ch, input int o);
    return 5'((ch << 3) | o);
  endfunction

  initial begin
    logic [31:0] rd;
    logic [4:0]  a25;
    logic [31:0] big;
    int          cmp;
    checks = 0;
    errors = 0;
    big = 32'h25;
    a25 = big[4:0];

    vecs[0]  = '{"rst_per0", 0, 0, 0, ad(0,2), 49999, 0, 0};
    vecs[1]  = '{"rst_cmp1", 0, 0, 0, ad(1,3), 0, 0, 0};
    vecs[2]  = '{"rst_ctl3", 0, 0, 0, ad(3,1), 0, 0, 0};
    vecs[3]  = '{"rst_cnt2", 0, 0, 0, ad(2,4), 0, 0, 0};
    vecs[4]  = '{"per_trunc", 1, ad(2,2), 32'hABCD1234,
                 ad(2,2), 32'h1234, 0, 0};
    vecs[5]  = '{"cmp_trunc", 1, ad(2,3), 32'hFFFF0055,
                 ad(2,3), 32'h55, 0, 0};
    vecs[6]  = '{"off5_ign", 1, ad(2,5), 32'hFFFFFFFF,
                 ad(2,5), 0, 0, 0};
    vecs[7]  = '{"off6_zero", 0, 0, 0, ad(2,6), 0, 0, 0};
    vecs[8]  = '{"off7_zero", 0, 0, 0, ad(2,7), 0, 0, 0};
    vecs[9]  = '{"start_stop", 1, ad(2,1), 32'h0C,
                 ad(2,0), 0, 1, 1'b0};
    vecs[10] = '{"ctl_rdback", 1, ad(2,1), 32'h1F,
                 ad(2,1), 32'h13, 1, 1'b1};
    vecs[11] = '{"ss_status", 0, 0, 0, ad(2,0), 0, 1, 1'b1};
    vecs[12] = '{"addr_0x25", 0, 0, 0, a25, 0, 0, 0};

    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick();
    tick();
    check("rst_irq", 32'(irq), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_rdata", bus.readdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) bus_wr(vecs[i].wa, vecs[i].wd);
      bus_rd(vecs[i].ra, rd);
      check(vecs[i].name, rd, vecs[i].exp);
      if (vecs[i].chk_pwm)
        check({vecs[i].name, "_pwm"}, 32'(pwm_out[2]),
              32'(vecs[i].pwm2));
    end
    bus_wr(ad(2,1), 32'h0);

    // ch0 continuous, PERIOD=9 COMPARE=3
    bus_wr(ad(0,2), 9);
    bus_wr(ad(0,3), 3);
    bus_wr(ad(0,1), 32'h06);
    check("c0_pwm_k0", 32'(pwm_out[0]), 1);
    bus.address = ad(0,0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("c0_pwm", 32'(pwm_out[0]), 32'((k % 10) < 3));
      check("c0_status", bus.readdata, (k >= 11) ? 3 : 2);
    end

    // ch1 one-shot with IE
    bus_wr(ad(1,2), 4);
    bus_wr(ad(1,1), 32'h05);
    check("c1_irq_k0", 32'(irq), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("c1_irq", 32'(irq), 32'(k == 5));
    end
    bus_rd(ad(1,0), rd);
    check("c1_status", rd, 1);
    bus_rd(ad(1,4), rd);
    check("c1_count", rd, 0);
    bus_wr(ad(1,0), 0);
    check("c1_irq_clr", 32'(irq), 0);

    // ch1 continuous: STATUS clear on the wrap edge loses to set
    bus_wr(ad(1,1), 32'h07);
    for (int k = 1; k <= 4; k++) tick();
    check("c1_pre_wrap", 32'(irq), 0);
    bus_wr(ad(1,0), 0);
    check("to_set_wins", 32'(irq), 1);
    bus_wr(ad(1,0), 0);
    check("to_clear", 32'(irq), 0);
    bus_wr(ad(1,1), 32'h08);
    bus_rd(ad(1,4), rd);
    check("stop_hold", rd, 1);
    bus_rd(ad(1,0), rd);
    check("stop_status", rd, 0);

    // ch3 COMPARE rewritten mid-period
    bus_wr(ad(3,2), 9);
    bus_wr(ad(3,3), 5);
    bus_wr(ad(3,1), 32'h06);
    for (int k = 0; k <= 22; k++) begin
      if (k == 3) bus_wr(ad(3,3), 8);
      else if (k > 0) tick();
      cmp = (SHADOW && k < 10) ? 5 : 8;
      if (k < 3) cmp = 5;
      check("c3_midcmp", 32'(pwm_out[3]), 32'((k % 10) < cmp));
    end

    // COMPARE=0 never active, COMPARE>PERIOD always active
    bus_wr(ad(3,1), 32'h08);
    check("c3_stop_pol", 32'(pwm_out[3]), 0);
    bus_wr(ad(3,3), 0);
    bus_wr(ad(3,1), 32'h06);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      check("c3_cmp0", 32'(pwm_out[3]), 0);
    end
    bus_wr(ad(3,1), 32'h08);
    bus_wr(ad(3,3), 12);
    bus_wr(ad(3,1), 32'h06);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      check("c3_cmpbig", 32'(pwm_out[3]), 1);
    end

    // PERIOD=0: timeout every cycle, count pinned at 0
    bus_wr(ad(3,1), 32'h08);
    bus_wr(ad(3,2), 0);
    bus_wr(ad(3,3), 1);
    bus_wr(ad(3,1), 32'h06);
    bus.address = ad(3,4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("p0_count", bus.readdata, 0);
    end
    bus_wr(ad(3,0), 0);
    bus_rd(ad(3,0), rd);
    check("p0_status", rd, 3);
    check("p0_pwm", 32'(pwm_out[3]), 1);
    bus_wr(ad(3,1), 32'h08);

    // Reset while ch0 runs with irq high, racing a write
    bus_wr(ad(0,1), 32'h03);
    check("c0_irq_on", 32'(irq), 1);
    reset          = 1'b1;
    bus.address    = ad(0,1);
    bus.writedata  = 32'h06;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check("rst2_irq", 32'(irq), 0);
    check("rst2_pwm", 32'(pwm_out), 0);
    check("rst2_rdata", bus.readdata, 0);
    reset = 1'b0;
    bus_rd(ad(0,2), rd);
    check("rst2_per", rd, 49999);
    bus_rd(ad(0,0), rd);
    check("rst2_status", rd, 0);
    bus_rd(ad(0,1), rd);
    check("rst2_ctl", rd, 0);
    bus_rd(ad(0,4), rd);
    check("rst2_count", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
